// File: rtl/escr_rtc.sv
// ============================================================================
// escr_rtc -- write sequencer for a multiplexed address/data bus RTC
//
// When a write is requested, this block pushes the time/date registers to
// the RTC one register per bus transaction. If the timer option is built in,
// it also pushes the timer registers. It then writes the transfer command
// last, so the RTC commits everything at once.
//
// The block sits beside the RTC read sequencer. Both share the RTC control
// pins and the tri-state data buffer through a mux at the top level. Register
// values come from the register bank: this block drives a select index (sel),
// and the bank answers combinationally on dato_in.
//
// Each transaction has four bus phases of T_PH cycles each:
//   ADDR : a_d=0 cs=0 wr=0, register address on dato_out
//   GAP1 : a_d=cs=wr=1, address still held on dato_out
//   DATA : a_d=1 cs=0 wr=0, data latched from dato_in on entry
//          (CMD_DATA on the final transaction)
//   GAP2 : a_d=cs=wr=1; the buffer is released in the last GAP2 cycle
//
// Compile-time option:
//   RTC_TIMER_WR_EN  when defined, timer registers tseg/tmin/thora
//                    (idx 6-8, addresses 8'h41-8'h43) are written before the
//                    command: 10 transactions. When undefined, only idx 0-5
//                    are written and then the command: 7 transactions.
//
// Parameters:
//   T_PH      cycles per bus phase (>= 2)
//   CMD_ADDR  transfer-command address (final transaction)
//   CMD_DATA  transfer-command data
//
// Ports:
//   clk            system clock
//   reset          synchronous, active-low reset
//   escribir       write request (level); only looked at while idle
//   dato_in        register-bank value for index sel
//   sel            register index: 0 seg,1 min,2 hora,3 dia,4 mes,5 anio,
//                  6 tseg,7 tmin,8 thora
//   dato_out       value driven onto the RTC AD bus (address or data)
//   a_d,cs,rd,wr   RTC control strobes, active-low (a_d=0 is address phase)
//   buffer_activo  tri-state enable for the shared AD buffer
//   ocupado        busy from the first ADDR cycle until DONE
//   listo          sequence complete; held until escribir drops
// ============================================================================
module escr_rtc #(
    parameter int unsigned T_PH     = 10,
    parameter logic [7:0]  CMD_ADDR = 8'hF1,
    parameter logic [7:0]  CMD_DATA = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       escribir,
    input  logic [7:0] dato_in,
    output logic [3:0] sel,
    output logic [7:0] dato_out,
    output logic       a_d,
    output logic       cs,
    output logic       rd,
    output logic       wr,
    output logic       buffer_activo,
    output logic       ocupado,
    output logic       listo
);

`ifdef RTC_TIMER_WR_EN
    localparam int unsigned N_REG = 9;
`else
    localparam int unsigned N_REG = 6;
`endif
    // One transaction per register plus the trailing transfer command.
    localparam int unsigned N_TX = N_REG + 1;

    localparam int unsigned   PW      = (T_PH > 2) ? $clog2(T_PH) : 1;
    localparam logic [PW-1:0] PH_LAST = PW'(T_PH - 1);
    localparam logic [PW-1:0] PH_PRE  = PW'(T_PH - 2);
    localparam logic [3:0]    TX_LAST = 4'(N_TX - 1);
    localparam logic [3:0]    SEL_END = 4'(N_REG);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        GAP1,
        DATA,
        GAP2,
        DONE
    } state_t;

    state_t        state_reg;
    logic [PW-1:0] phase_reg;
    logic [3:0]    tx_reg;
    logic [3:0]    tx_next;
    logic          phase_end;
    logic          tx_is_last;

    // ------------------------------------------------------------------------
    // Address table, indexed by transaction number. The table has 16 entries
    // so the 4-bit transaction counter can index it directly. Entries past
    // the last register all read as the command address. Only the entry at
    // N_TX-1 is ever used for the command.
    // ------------------------------------------------------------------------
    logic [7:0] addr_rom [16];

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_addr_rom
            if (gi >= N_TX - 1) begin : g_cmd
                assign addr_rom[gi] = CMD_ADDR;
            end else if (gi < 6) begin : g_clock
                assign addr_rom[gi] = 8'(8'h21 + gi);
            end else begin : g_timer
                assign addr_rom[gi] = 8'(8'h41 + (gi - 6));
            end
        end
    endgenerate

    assign phase_end  = (phase_reg == PH_LAST);
    assign tx_is_last = (tx_reg == TX_LAST);
    assign tx_next    = tx_reg + 4'd1;

    // The write sequencer never reads from the RTC.
    assign rd = 1'b1;

    // ------------------------------------------------------------------------
    // Sequencer. All outputs are registered and are updated on the same edge
    // as the state they belong to. Because of this, each phase lasts exactly
    // T_PH cycles on the pins.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg     <= IDLE;
            phase_reg     <= '0;
            tx_reg        <= '0;
            sel           <= 4'd0;
            dato_out      <= 8'h00;
            a_d           <= 1'b1;
            cs            <= 1'b1;
            wr            <= 1'b1;
            buffer_activo <= 1'b0;
            ocupado       <= 1'b0;
            listo         <= 1'b0;
        end else begin
            unique case (state_reg)
                IDLE: begin
                    if (escribir) begin
                        state_reg     <= ADDR;
                        phase_reg     <= '0;
                        tx_reg        <= 4'd0;
                        sel           <= 4'd0;
                        dato_out      <= addr_rom[0];
                        a_d           <= 1'b0;
                        cs            <= 1'b0;
                        wr            <= 1'b0;
                        buffer_activo <= 1'b1;
                        ocupado       <= 1'b1;
                        listo         <= 1'b0;
                    end
                end

                ADDR: begin
                    if (phase_end) begin
                        state_reg <= GAP1;
                        phase_reg <= '0;
                        a_d       <= 1'b1;
                        cs        <= 1'b1;
                        wr        <= 1'b1;
                    end else begin
                        phase_reg <= phase_reg + 1'b1;
                    end
                end

                GAP1: begin
                    if (phase_end) begin
                        state_reg <= DATA;
                        phase_reg <= '0;
                        cs        <= 1'b0;
                        wr        <= 1'b0;
                        // Data is captured once, here. Any later movement on
                        // dato_in does not reach the bus.
                        dato_out  <= tx_is_last ? CMD_DATA : dato_in;
                    end else begin
                        phase_reg <= phase_reg + 1'b1;
                    end
                end

                DATA: begin
                    if (phase_end) begin
                        state_reg <= GAP2;
                        phase_reg <= '0;
                        cs        <= 1'b1;
                        wr        <= 1'b1;
                    end else begin
                        phase_reg <= phase_reg + 1'b1;
                    end
                end

                GAP2: begin
                    if (phase_end) begin
                        phase_reg <= '0;
                        if (tx_is_last) begin
                            state_reg     <= DONE;
                            dato_out      <= 8'h00;
                            buffer_activo <= 1'b0;
                            ocupado       <= 1'b0;
                            listo         <= 1'b1;
                        end else begin
                            state_reg     <= ADDR;
                            tx_reg        <= tx_next;
                            // The command transaction keeps the last
                            // register index, so sel stays inside the bank.
                            if (tx_next < SEL_END) begin
                                sel <= tx_next;
                            end
                            dato_out      <= addr_rom[tx_next];
                            a_d           <= 1'b0;
                            cs            <= 1'b0;
                            wr            <= 1'b0;
                            buffer_activo <= 1'b1;
                        end
                    end else begin
                        phase_reg <= phase_reg + 1'b1;
                        // Release the buffer one cycle before the
                        // transaction ends. This leaves a turnaround cycle
                        // for whoever drives the shared bus next.
                        if (phase_reg == PH_PRE) begin
                            buffer_activo <= 1'b0;
                        end
                    end
                end

                DONE: begin
                    // Holding here while the request is still high keeps a
                    // level request from starting a second sequence.
                    if (!escribir) begin
                        state_reg <= IDLE;
                        listo     <= 1'b0;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_escr_rtc.sv
module tb_escr_rtc;

    localparam int T_PH  = 4;
    localparam int TX_CY = 4 * T_PH;
`ifdef RTC_TIMER_WR_EN
    localparam int N_REG = 9;
`else
    localparam int N_REG = 6;
`endif
    localparam int N_TX = N_REG + 1;

    logic       clk;
    logic       reset;
    logic       escribir;
    logic [7:0] dato_in;
    logic [3:0] sel;
    logic [7:0] dato_out;
    logic       a_d, cs, rd, wr, buffer_activo, ocupado, listo;

    logic [7:0] bank [16];
    logic [7:0] noise;

    int n_checks = 0;
    int n_pass   = 0;

    // Expected address/data pairs for the current sequence.
    logic [7:0] exp_addr [16];
    logic [7:0] exp_data [16];

    escr_rtc #(.T_PH(T_PH), .CMD_ADDR(8'hF1), .CMD_DATA(8'h00)) dut (
        .clk           (clk),
        .reset         (reset),
        .escribir      (escribir),
        .dato_in       (dato_in),
        .sel           (sel),
        .dato_out      (dato_out),
        .a_d           (a_d),
        .cs            (cs),
        .rd            (rd),
        .wr            (wr),
        .buffer_activo (buffer_activo),
        .ocupado       (ocupado),
        .listo         (listo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The register bank answers combinationally. noise lets the bench disturb
    // dato_in while the DUT is in the DATA phase.
    always_comb dato_in = bank[sel] ^ noise;

    logic [18:0] obs;
    assign obs = {a_d, cs, rd, wr, buffer_activo, ocupado, listo, sel, dato_out};

    localparam logic [3:0]  SEL_LAST = 4'(N_REG - 1);
    localparam logic [18:0] RESET_V  = {7'b1111_000, 4'd0, 8'h00};
    localparam logic [18:0] DONE_V   = {7'b1111_001, SEL_LAST, 8'h00};
    localparam logic [18:0] IDLE_V   = {7'b1111_000, SEL_LAST, 8'h00};

    task automatic check(input string tag, input logic [18:0] got, input logic [18:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Model: the address and data of each transaction, taken from the
    // register map.
    task automatic build_model();
        for (int i = 0; i < N_REG; i++) begin
            exp_addr[i] = (i < 6) ? 8'(8'h21 + i) : 8'(8'h41 + i - 6);
            exp_data[i] = bank[i];
        end
        exp_addr[N_TX-1] = 8'hF1;
        exp_data[N_TX-1] = 8'h00;
    endtask

    // Expected pin state in cycle c, counted from the first ADDR cycle.
    function automatic logic [18:0] exp_bus(input int c);
        int tx;
        int ph;
        int pc;
        logic [3:0] s;
        logic [7:0] d;
        logic strobe;
        tx = c / TX_CY;
        ph = (c % TX_CY) / T_PH;
        pc = c % T_PH;
        s  = 4'((tx < N_REG) ? tx : N_REG - 1);
        d  = (ph < 2) ? exp_addr[tx] : exp_data[tx];
        strobe = !(ph == 0 || ph == 2);
        return {ph != 0, strobe, 1'b1, strobe, !(ph == 3 && pc == T_PH - 1),
                1'b1, 1'b0, s, d};
    endfunction

    // Runs one sequence. Call it at a negedge with the DUT idle.
    //   tgl      : disturb dato_in during DATA
    //   hold     : extra DONE cycles with escribir held high (0 = 1-cycle pulse)
    //   abort_at : cycle at which reset is asserted (-1 = never)
    task automatic run_seq(input bit tgl, input int hold, input int abort_at);
        int ph;
        build_model();
        escribir = 1'b1;
        @(negedge clk);
        for (int c = 0; c < N_TX * TX_CY; c++) begin
            if (c == abort_at) begin
                reset    = 1'b0;
                escribir = 1'b0;
                noise    = 8'h00;
                $display("tx %0d aborted by reset at cycle %0d", c / TX_CY, c);
                return;
            end
            check($sformatf("bus_tx%0d_c%0d", c / TX_CY, c), obs, exp_bus(c));
            if (c == 0 && hold == 0) escribir = 1'b0;
            ph = (c % TX_CY) / T_PH;
            noise = (tgl && ph == 2) ? 8'($urandom_range(1, 255)) : 8'h00;
            if (c % TX_CY == TX_CY - 1)
                $display("tx %0d addr %h data %h", c / TX_CY, exp_addr[c / TX_CY],
                         exp_data[c / TX_CY]);
            @(negedge clk);
        end
        noise = 8'h00;
        check("done_latency", obs, DONE_V);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check($sformatf("done_hold%0d", h), obs, DONE_V);
        end
        escribir = 1'b0;
        @(negedge clk);
        check("back_to_idle", obs, IDLE_V);
        @(negedge clk);
        check("stay_idle", obs, IDLE_V);
    endtask

    initial begin
        reset    = 1'b0;
        escribir = 1'b1;
        noise    = 8'h00;
        for (int i = 0; i < 16; i++) bank[i] = 8'(i * 8'h11);

        // Reset held with a pending request: nothing may move.
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("reset_%0d", i), obs, RESET_V);
        end
        escribir = 1'b0;
        reset    = 1'b1;
        @(negedge clk);
        check("idle_after_reset", obs, RESET_V);

        // Pulse request, bank = sel*0x11.
        run_seq(1'b0, 0, -1);
        // Held request through DONE.
        run_seq(1'b0, 5, -1);
        // dato_in disturbed during DATA.
        run_seq(1'b1, 0, -1);

        // Reset in the middle of DATA of transaction 3, then restart.
        run_seq(1'b0, 0, 3 * TX_CY + 2 * T_PH + 1);
        @(negedge clk);
        check("abort_reset", obs, RESET_V);
        reset = 1'b1;
        run_seq(1'b0, 0, -1);

        // Random bank contents and random options.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 16; i++) bank[i] = 8'($urandom_range(0, 255));
            run_seq(1'($urandom_range(0, 1)), $urandom_range(0, 3), -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
